// File: rtl/csr_spmv_seq.sv
// csr_spmv_seq: CSR sparse matrix-vector sequencer, one y element per row over two combinational read ports
module csr_spmv_seq #(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int ACC_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [AW-1:0]    i_row_base,
   input  logic [AW-1:0]    i_col_base,
   input  logic [AW-1:0]    i_val_base,
   input  logic [AW-1:0]    i_vec_base,
   input  logic [AW-1:0]    i_num_rows,
   output logic [AW-1:0]    o_addr1,
   input  logic [DW-1:0]    i_data_in1,
   output logic [AW-1:0]    o_addr2,
   input  logic [DW-1:0]    i_data_in2,
   output logic             o_y_valid,
   output logic [AW-1:0]    o_y_row,
   output logic [ACC_W-1:0] o_y_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);
   typedef enum logic [2:0] {S_IDLE, S_RP0, S_RP1, S_CI, S_VX, S_EMIT, S_DONE} state_t;
   state_t r_state, w_next;
   logic [AW-1:0] r_row_base, r_col_base, r_val_base, r_vec_base, r_num_rows;
   logic [AW-1:0] r_k, r_kend, r_r, r_col, r_y_row;
   logic [DW-1:0] r_val;
   logic [ACC_W-1:0] r_acc, r_y_data;
   logic r_err;
   logic [AW-1:0] w_d1, w_k1, w_r1;
   logic w_emit;
   assign w_d1 = AW'(i_data_in1);
   assign w_k1 = r_k + AW'(1);
   assign w_r1 = r_r + AW'(1);
   assign w_emit = (r_state == S_EMIT);
   assign o_y_valid = w_emit;
   assign o_y_row = w_emit ? r_r : r_y_row;
   assign o_y_data = w_emit ? r_acc : r_y_data;
   assign o_busy = (r_state != S_IDLE);
   assign o_done = (r_state == S_DONE);
   assign o_err = r_err;
   // state register; async reset abandons any run in flight
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_state <= S_IDLE;
      else r_state <= w_next;
   // next state and read addresses; addresses rest at 0 outside fetch states
   always_comb begin
      w_next = r_state;
      o_addr1 = '0;
      o_addr2 = '0;
      case (r_state)
         S_IDLE: if (i_start) w_next = (i_num_rows == '0) ? S_DONE : S_RP0;
         S_RP0: begin
            o_addr1 = r_row_base;
            w_next = S_RP1;
         end
         S_RP1: begin
            o_addr1 = r_row_base + w_r1;
            w_next = (w_d1 <= r_k) ? S_EMIT : S_CI;
         end
         S_CI: begin
            o_addr1 = r_col_base + r_k;
            o_addr2 = r_val_base + r_k;
            w_next = S_VX;
         end
         S_VX: begin
            o_addr2 = r_vec_base + r_col;
            w_next = (w_k1 == r_kend) ? S_EMIT : S_CI;
         end
         S_EMIT: w_next = (w_r1 == r_num_rows) ? S_DONE : S_RP1;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end
   // datapath: latch run parameters, walk indices, multiply-accumulate, hold last y
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_row_base <= '0;
         r_col_base <= '0;
         r_val_base <= '0;
         r_vec_base <= '0;
         r_num_rows <= '0;
         r_k <= '0;
         r_kend <= '0;
         r_r <= '0;
         r_col <= '0;
         r_val <= '0;
         r_acc <= '0;
         r_err <= 1'b0;
         r_y_row <= '0;
         r_y_data <= '0;
      end else
         case (r_state)
            S_IDLE: if (i_start) begin
               r_row_base <= i_row_base;
               r_col_base <= i_col_base;
               r_val_base <= i_val_base;
               r_vec_base <= i_vec_base;
               r_num_rows <= i_num_rows;
               r_k <= '0;
               r_kend <= '0;
               r_r <= '0;
               r_acc <= '0;
               r_err <= 1'b0;
            end
            S_RP0: r_k <= w_d1;
            S_RP1: begin
               r_kend <= w_d1;
               if (w_d1 < r_k) r_err <= 1'b1;
            end
            S_CI: begin
               r_col <= w_d1;
               r_val <= i_data_in2;
            end
            S_VX: begin
               r_acc <= r_acc + ACC_W'(r_val) * ACC_W'(i_data_in2);
               r_k <= w_k1;
            end
            S_EMIT: begin
               r_y_row <= r_r;
               r_y_data <= r_acc;
               r_acc <= '0;
               r_r <= w_r1;
               r_k <= r_kend;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_csr_spmv_seq.sv
// tb_csr_spmv_seq: directed scoreboard bench for the CSR sequencer against a behavioural memory and model
module tb_csr_spmv_seq;
   typedef struct packed {
      logic [31:0] row;
      logic [31:0] data;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] rb, cb, vb, xb, num_rows;
   logic [31:0] addr1, addr2, data_in1, data_in2, y_row, y_data;
   logic y_valid, busy, done, err;
   logic [31:0] mem [0:255];
   exp_t q[$];
   int checks = 0, errors = 0;
   int cyc, first_yv, done_cyc, done_cnt, yv_cnt;
   logic addr_nz, busy_done;
   csr_spmv_seq dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_row_base(rb), .i_col_base(cb), .i_val_base(vb), .i_vec_base(xb),
      .i_num_rows(num_rows),
      .o_addr1(addr1), .i_data_in1(data_in1),
      .o_addr2(addr2), .i_data_in2(data_in2),
      .o_y_valid(y_valid), .o_y_row(y_row), .o_y_data(y_data),
      .o_busy(busy), .o_done(done), .o_err(err)
   );
   always #5 clk = ~clk;
   assign data_in1 = (addr1 < 256) ? mem[addr1[7:0]] : '0;
   assign data_in2 = (addr2 < 256) ? mem[addr2[7:0]] : '0;
   function automatic logic [31:0] rd(input logic [31:0] a);
      return (a < 256) ? mem[a[7:0]] : '0;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic clr();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask
   task automatic model(input logic [31:0] n, output logic e);
      logic [31:0] ks, ke, acc;
      e = 1'b0;
      for (logic [31:0] r = 0; r < n; r++) begin
         ks = rd(rb + r);
         ke = rd(rb + r + 1);
         if (ke < ks) e = 1'b1;
         acc = '0;
         for (logic [31:0] k = ks; k < ke; k++) acc = acc + rd(vb + k) * rd(xb + rd(cb + k));
         q.push_back('{row: r, data: acc});
      end
   endtask
   task automatic step();
      exp_t ex;
      @(negedge clk);
      cyc++;
      if (addr1 !== 0 || addr2 !== 0) addr_nz = 1'b1;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         busy_done = busy;
      end
      if (y_valid) begin
         yv_cnt++;
         if (first_yv == 0) first_yv = cyc;
         chk("y_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            ex = q.pop_front();
            chk("y_row", y_row, ex.row);
            chk("y_data", y_data, ex.data);
         end
      end
   endtask
   task automatic launch(input logic [31:0] n, input int pulse_at);
      logic e;
      model(n, e);
      num_rows = n;
      cyc = 0; first_yv = 0; done_cyc = 0; done_cnt = 0; yv_cnt = 0;
      addr_nz = 1'b0; busy_done = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("err_cleared", 32'(err), 0);
      if (n != 0) chk("rp0_addr", addr1, rb);
      while (done_cnt == 0 && cyc < 2000) begin
         if (cyc == pulse_at) start = 1'b1;
         step();
         start = 1'b0;
      end
      chk("done_seen", done_cnt, 1);
      chk("q_drained", q.size(), 0);
      repeat (3) step();
      chk("single_done", done_cnt, 1);
      chk("busy_idle", 32'(busy), 0);
      chk("err", 32'(err), 32'(e));
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      logic e;
      clr();
      rb = 0; cb = 16; vb = 32; xb = 128; num_rows = 0;
      cyc = 0; first_yv = 0; done_cyc = 0; done_cnt = 0; yv_cnt = 0; addr_nz = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_y_valid", 32'(y_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_y_row", y_row, 0);
      chk("rst_y_data", y_data, 0);
      chk("rst_addr1", addr1, 0);
      chk("rst_addr2", addr2, 0);
      rst = 1'b0;
      // single row, five nonzeros
      mem[0] = 0; mem[1] = 5;
      mem[16] = 3; mem[17] = 4; mem[18] = 6; mem[19] = 8; mem[20] = 9;
      mem[32] = 82; mem[33] = 9; mem[34] = 27; mem[35] = 28; mem[36] = 97;
      mem[131] = 36; mem[132] = 96; mem[134] = 15; mem[136] = 64; mem[137] = 43;
      launch(1, -1);
      chk("t2_yv_cycle", first_yv, 13);
      chk("t2_done_cycle", done_cyc, 14);
      chk("t2_busy_at_done", 32'(busy_done), 1);
      chk("t2_hold_data", y_data, 10184);
      chk("t2_hold_row", y_row, 0);
      // zero rows
      launch(0, -1);
      chk("t3_done_cycle", done_cyc, 1);
      chk("t3_no_y", yv_cnt, 0);
      chk("t3_addr_zero", 32'(addr_nz), 0);
      // empty first row
      clr();
      mem[0] = 0; mem[1] = 0; mem[2] = 2;
      mem[16] = 1; mem[17] = 2; mem[32] = 5; mem[33] = 7;
      mem[129] = 11; mem[130] = 13;
      launch(2, -1);
      chk("t4_empty_row_cycle", first_yv, 3);
      chk("t4_row1", y_data, 146);
      // decreasing row pointer
      clr();
      mem[0] = 4; mem[1] = 2;
      launch(1, -1);
      chk("t5_err", 32'(err), 1);
      chk("t5_y_zero", y_data, 0);
      // wrap arithmetic and start while busy
      clr();
      mem[0] = 0; mem[1] = 2; mem[16] = 0; mem[17] = 1;
      mem[32] = 32'hFFFF_FFFF; mem[33] = 32'hFFFF_FFFF;
      mem[128] = 32'hFFFF_FFFF; mem[129] = 32'hFFFF_FFFF;
      launch(1, 3);
      chk("t6_wrap", y_data, 2);
      // reset during VX of row 2
      clr();
      mem[0] = 0; mem[1] = 1; mem[2] = 2; mem[3] = 4;
      mem[16] = 0; mem[17] = 1; mem[18] = 2; mem[19] = 3;
      mem[32] = 2; mem[33] = 3; mem[34] = 4; mem[35] = 5;
      mem[128] = 10; mem[129] = 20; mem[130] = 30; mem[131] = 40;
      model(2, e);
      num_rows = 3;
      cyc = 0; first_yv = 0; done_cnt = 0; yv_cnt = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (cyc < 12) step();
      chk("t1_rows_before_rst", yv_cnt, 2);
      rst = 1'b1;
      #1;
      chk("t1_busy_drop", 32'(busy), 0);
      chk("t1_addr2_zero", addr2, 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (2) step();
      chk("t1_no_done", done_cnt, 0);
      chk("t1_no_extra_y", yv_cnt, 2);
      chk("t1_q_drained", q.size(), 0);
      launch(3, -1);
      chk("t1_row2", y_data, 320);
      chk("t1_row2_idx", y_row, 2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
